// File: rtl/alarm_controller_pkg.sv
// ============================================================================
// Module : alarm_controller_pkg
// Brief  : Shared alarm FSM state codes and counter-width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alarm_controller_pkg;

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_RINGING  = 2'd2,
        S_SNOOZE   = 2'd3
    } alarm_state_t;

    // Width needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_controller_if.sv
// ============================================================================
// Module : alarm_controller_if
// Brief  : Tick/button/match inputs and buzzer/status outputs of the alarm FSM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface alarm_controller_if;

    logic sec;
    logic min;
    logic match;
    logic arm_btn;
    logic snooze_btn;
    logic buzzer;
    logic armed;
    logic ringing;
    logic snoozing;

    modport master (
        output sec, min, match, arm_btn, snooze_btn,
        input  buzzer, armed, ringing, snoozing
    );

    modport slave (
        input  sec, min, match, arm_btn, snooze_btn,
        output buzzer, armed, ringing, snoozing
    );

endinterface

`default_nettype wire

// File: rtl/alarm_controller_rise_detect.sv
// ============================================================================
// Module : alarm_controller_rise_detect
// Brief  : Rising-edge detector; history resets high so a held level never fires.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alarm_controller_rise_detect (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic in_i,
    output logic      rise_o
);

    logic in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in_i;
        end
    end

    assign rise_o = in_i & ~in_q;

endmodule

`default_nettype wire

// File: rtl/alarm_controller.sv
// ============================================================================
// Module : alarm_controller
// Brief  : Alarm sequencer: arm/disarm, ring on match, limited snooze, timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int MAX_SNOOZE     = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alarm_controller_if.slave  bus
);

    localparam int RW = cnt_width(RING_SECONDS);
    localparam int MW = cnt_width(SNOOZE_MINUTES);
    localparam int SW = cnt_width(MAX_SNOOZE);

    localparam logic [RW-1:0] C_RING_LAST   = RW'(RING_SECONDS - 1);
    localparam logic [MW-1:0] C_SNOOZE_LAST = MW'(SNOOZE_MINUTES - 1);
    localparam logic [SW-1:0] C_SNOOZE_MAX  = SW'(MAX_SNOOZE);

    logic w_arm_rise;
    logic w_snooze_rise;
    logic w_match_rise;

    alarm_controller_rise_detect u_arm_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (bus.arm_btn),
        .rise_o (w_arm_rise)
    );

    alarm_controller_rise_detect u_snooze_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (bus.snooze_btn),
        .rise_o (w_snooze_rise)
    );

    alarm_controller_rise_detect u_match_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (bus.match),
        .rise_o (w_match_rise)
    );

    alarm_state_t  state_q;
    logic [RW-1:0] ring_cnt_q;
    logic [MW-1:0] min_cnt_q;
    logic [SW-1:0] snooze_cnt_q;
    logic          phase_q;
    logic          buzzer_q;
    logic          armed_q;
    logic          ringing_q;
    logic          snoozing_q;

    // Outputs are loaded from the next state, so they move on the same edge as state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_DISARMED;
            ring_cnt_q   <= '0;
            min_cnt_q    <= '0;
            snooze_cnt_q <= '0;
            phase_q      <= 1'b0;
            buzzer_q     <= 1'b0;
            armed_q      <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            case (state_q)
                S_DISARMED: begin
                    if (w_arm_rise) begin
                        state_q <= S_ARMED;
                        armed_q <= 1'b1;
                    end
                end

                S_ARMED: begin
                    if (w_arm_rise) begin
                        state_q <= S_DISARMED;
                        armed_q <= 1'b0;
                    end else if (w_match_rise) begin
                        state_q    <= S_RINGING;
                        ring_cnt_q <= '0;
                        phase_q    <= 1'b1;
                        buzzer_q   <= 1'b1;
                        ringing_q  <= 1'b1;
                    end
                end

                S_RINGING: begin
                    if (w_arm_rise) begin
                        state_q      <= S_ARMED;
                        snooze_cnt_q <= '0;
                        buzzer_q     <= 1'b0;
                        ringing_q    <= 1'b0;
                    end else if (w_snooze_rise && (snooze_cnt_q < C_SNOOZE_MAX)) begin
                        state_q      <= S_SNOOZE;
                        snooze_cnt_q <= snooze_cnt_q + SW'(1);
                        min_cnt_q    <= '0;
                        buzzer_q     <= 1'b0;
                        ringing_q    <= 1'b0;
                        snoozing_q   <= 1'b1;
                    end else if (bus.sec) begin
                        if (ring_cnt_q == C_RING_LAST) begin
                            state_q      <= S_ARMED;
                            snooze_cnt_q <= '0;
                            buzzer_q     <= 1'b0;
                            ringing_q    <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + RW'(1);
                            phase_q    <= ~phase_q;
                            buzzer_q   <= ~phase_q;
                        end
                    end
                end

                S_SNOOZE: begin
                    if (w_arm_rise) begin
                        state_q      <= S_ARMED;
                        snooze_cnt_q <= '0;
                        snoozing_q   <= 1'b0;
                    end else if (bus.min) begin
                        if (min_cnt_q == C_SNOOZE_LAST) begin
                            state_q    <= S_RINGING;
                            ring_cnt_q <= '0;
                            phase_q    <= 1'b1;
                            buzzer_q   <= 1'b1;
                            ringing_q  <= 1'b1;
                            snoozing_q <= 1'b0;
                        end else begin
                            min_cnt_q <= min_cnt_q + MW'(1);
                        end
                    end
                end

                default: begin
                    state_q    <= S_DISARMED;
                    buzzer_q   <= 1'b0;
                    armed_q    <= 1'b0;
                    ringing_q  <= 1'b0;
                    snoozing_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.buzzer   = buzzer_q;
    assign bus.armed    = armed_q;
    assign bus.ringing  = ringing_q;
    assign bus.snoozing = snoozing_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// ============================================================================
// Module : tb_alarm_controller
// Brief  : Directed self-checking bench for alarm_controller (4 s ring, 2 min snooze, 1 snooze).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alarm_controller;

    logic clk;
    logic rst_n;
    int   r_checks;
    int   r_errors;

    alarm_controller_if ifc ();

    alarm_controller #(
        .RING_SECONDS   (4),
        .SNOOZE_MINUTES (2),
        .MAX_SNOOZE     (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {buzzer, armed, ringing, snoozing}
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {ifc.buzzer, ifc.armed, ifc.ringing, ifc.snoozing};
    endfunction

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sec();
        ifc.sec = 1'b1;
        step();
        ifc.sec = 1'b0;
    endtask

    task automatic pulse_min();
        ifc.min = 1'b1;
        step();
        ifc.min = 1'b0;
    endtask

    task automatic toggle_arm();
        ifc.arm_btn = 1'b0;
        step();
        ifc.arm_btn = 1'b1;
        step();
    endtask

    task automatic raise_match();
        ifc.match = 1'b0;
        step();
        ifc.match = 1'b1;
        step();
    endtask

    initial begin
        r_checks       = 0;
        r_errors       = 0;
        ifc.sec        = 1'b0;
        ifc.min        = 1'b0;
        ifc.match      = 1'b1;
        ifc.arm_btn    = 1'b1;
        ifc.snooze_btn = 1'b0;
        rst_n          = 1'b0;

        // 1: reset with match and arm held high
        #3;
        check("reset_outs", outs(), 4'b0000);
        step(2);
        rst_n = 1'b1;
        step(3);
        check("held_levels_no_edge", outs(), 4'b0000);
        ifc.arm_btn = 1'b0;
        step();
        check("arm_fall_no_action", outs(), 4'b0000);
        ifc.arm_btn = 1'b1;
        step();
        check("armed_after_rise", outs(), 4'b0100);
        step(2);
        check("match_held_no_ring", outs(), 4'b0100);

        // 2: ring, buzzer toggles per sec, timeout on 4th sec
        raise_match();
        check("ring_start", outs(), 4'b1110);
        step(3);
        check("ring_hold_no_sec", outs(), 4'b1110);
        pulse_sec();
        check("ring_sec1", outs(), 4'b0110);
        pulse_sec();
        check("ring_sec2", outs(), 4'b1110);
        pulse_sec();
        check("ring_sec3", outs(), 4'b0110);
        pulse_sec();
        check("ring_timeout", outs(), 4'b0100);
        step(3);
        check("timeout_match_held", outs(), 4'b0100);

        // 3: snooze, re-ring after 2 min, second snooze refused
        raise_match();
        check("ring2_start", outs(), 4'b1110);
        ifc.snooze_btn = 1'b1;
        step();
        check("snooze_enter", outs(), 4'b0101);
        ifc.snooze_btn = 1'b0;
        pulse_sec();
        check("snooze_ignores_sec", outs(), 4'b0101);
        pulse_min();
        check("snooze_min1", outs(), 4'b0101);
        pulse_min();
        check("snooze_rering", outs(), 4'b1110);
        ifc.snooze_btn = 1'b1;
        step();
        check("snooze_max_ignored", outs(), 4'b1110);
        ifc.snooze_btn = 1'b0;
        pulse_sec();
        check("rering_sec1", outs(), 4'b0110);
        toggle_arm();
        check("arm_stop", outs(), 4'b0100);

        // 4: arm+snooze+sec together while ringing; arm wins and clears snooze count
        raise_match();
        check("ring3_start", outs(), 4'b1110);
        ifc.arm_btn = 1'b0;
        step();
        ifc.arm_btn    = 1'b1;
        ifc.snooze_btn = 1'b1;
        ifc.sec        = 1'b1;
        step();
        ifc.sec = 1'b0;
        check("priority_arm_wins", outs(), 4'b0100);
        ifc.snooze_btn = 1'b0;
        raise_match();
        check("ring4_start", outs(), 4'b1110);
        ifc.snooze_btn = 1'b1;
        step();
        check("snooze_after_clear", outs(), 4'b0101);
        ifc.snooze_btn = 1'b0;
        toggle_arm();
        check("snooze_cancel", outs(), 4'b0100);

        // 5: disarm, then match ignored
        toggle_arm();
        check("disarm", outs(), 4'b0000);
        raise_match();
        check("disarmed_match_ignored", outs(), 4'b0000);

        // 6: asynchronous reset mid-ring
        toggle_arm();
        raise_match();
        check("ring5_start", outs(), 4'b1110);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_silent", outs(), 4'b0000);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("after_reset_disarmed", outs(), 4'b0000);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule

`default_nettype wire
